// File: rtl/srt_div_seq_ctrl_if.sv
// Operand/result handshake bundle for the radix-4 mantissa divider controller.
interface srt_div_seq_ctrl_if #(
  parameter int WIDTH = 24,
  parameter int ITER  = 13
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    dividend;
  logic [WIDTH-1:0]    divisor;
  logic                out_valid;
  logic                out_ready;
  logic [2*ITER-1:0]   quotient;
  logic                sticky;
  logic                div_by_zero;
  logic                busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, sticky, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, sticky, div_by_zero, busy
  );
endinterface

// File: rtl/srt_div_seq_ctrl.sv
// Iterative radix-4 mantissa divider: one exact digit per clock, then a single
// negative-remainder fix-up. Optional early exit on zero remainder: SRT_DIV_EARLY_TERM_EN.
module srt_div_seq_ctrl #(
  parameter int WIDTH = 24,
  parameter int ITER  = 13
) (
  input  logic               clk,
  input  logic               rst,
  srt_div_seq_ctrl_if.slave  bus
);
  localparam int RW = WIDTH + 4;
  localparam int QW = 2 * ITER + 2;
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, ITERATE, CORRECT, DONE} state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       r_q, r_d;
  logic [RW-1:0]       d_q, d_d;
  logic [QW-1:0]       q_acc_q, q_acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*ITER-1:0]   quotient_q, quotient_d;
  logic                sticky_q, sticky_d;
  logic                dbz_q, dbz_d;

  // Digit selection datapath; remainder and accumulator are two's complement.
  logic [RW-1:0]       s_val, s_mag, d2, d3, kd, r_step, r_fix;
  logic                s_neg;
  logic [1:0]          k;
  logic [QW-1:0]       digit, q_step, q_fix;
`ifdef SRT_DIV_EARLY_TERM_EN
  logic [CW-1:0]       rem_digits;
`endif

  always_comb begin
    s_val  = r_q << 2;
    s_neg  = s_val[RW-1];
    s_mag  = s_neg ? (~s_val + 1'b1) : s_val;
    d2     = d_q << 1;
    d3     = d_q + d2;
    if (s_mag >= d3)       k = 2'd3;
    else if (s_mag >= d2)  k = 2'd2;
    else if (s_mag >= d_q) k = 2'd1;
    else                   k = 2'd0;
    case (k)
      2'd3:    kd = d3;
      2'd2:    kd = d2;
      2'd1:    kd = d_q;
      default: kd = '0;
    endcase
    r_step = s_neg ? (s_val + kd) : (s_val - kd);
    digit  = {{(QW-2){1'b0}}, k};
    q_step = (q_acc_q << 2) + (s_neg ? (~digit + 1'b1) : digit);
    q_fix  = r_q[RW-1] ? (q_acc_q - 1'b1) : q_acc_q;
    r_fix  = r_q[RW-1] ? (r_q + d_q) : r_q;
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    d_d        = d_q;
    q_acc_d    = q_acc_q;
    cnt_d      = cnt_q;
    quotient_d = quotient_q;
    sticky_d   = sticky_q;
    dbz_d      = dbz_q;
`ifdef SRT_DIV_EARLY_TERM_EN
    rem_digits = CW'(ITER - 1) - cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // d is held at twice the divisor so the initial remainder is below it.
          r_d      = {4'b0000, bus.dividend};
          d_d      = {3'b000, bus.divisor, 1'b0};
          cnt_d    = '0;
          q_acc_d  = '0;
          sticky_d = 1'b0;
          dbz_d    = (bus.divisor == '0);
          if (bus.divisor == '0) begin
            quotient_d = '1;
            state_d    = DONE;
          end else begin
            state_d    = ITERATE;
          end
        end
      end
      ITERATE: begin
        r_d     = r_step;
        q_acc_d = q_step;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = CORRECT;
        end
`ifdef SRT_DIV_EARLY_TERM_EN
        else if (r_step == '0) begin
          // Remaining digits are all zero; align as if they had been shifted in.
          q_acc_d = q_step << {rem_digits, 1'b0};
          state_d = CORRECT;
        end
`endif
      end
      CORRECT: begin
        r_d        = r_fix;
        q_acc_d    = q_fix;
        quotient_d = q_fix[2*ITER-1:0];
        sticky_d   = |r_fix;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      r_q        <= '0;
      d_q        <= '0;
      q_acc_q    <= '0;
      cnt_q      <= '0;
      quotient_q <= '0;
      sticky_q   <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      d_q        <= d_d;
      q_acc_q    <= q_acc_d;
      cnt_q      <= cnt_d;
      quotient_q <= quotient_d;
      sticky_q   <= sticky_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.sticky      = sticky_q;
  assign bus.div_by_zero = dbz_q;
endmodule
